// File: rtl/exc_entry_ctrl.sv
// exc_entry_ctrl: exception entry/return sequencer driving the banked
// register file and CPSR/SPSR write ports.
// Optional macro EXC_HIVEC_EN: when defined, vectors sit at 0xFFFF_0000
// and VECTOR_BASE is ignored; otherwise vectors sit at VECTOR_BASE.
module exc_entry_ctrl #(
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0000,
    parameter logic [31:0] IRQ_LR_OFS  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fiq_req,
    input  logic        irq_req,
    input  logic        und_req,
    input  logic        svc_req,
    input  logic        eret_req,
    input  logic [31:0] cpsr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] lr_in,
    output logic        busy,
    output logic [2:0]  Change_M,
    output logic        W_SPSR_s,
    output logic        Write_SPSR,
    output logic [2:0]  W_CPSR_s,
    output logic        Write_CPSR,
    output logic        Write_Reg,
    output logic [3:0]  W_Addr,
    output logic [31:0] W_Data,
    output logic        Write_PC,
    output logic [31:0] PC_New,
    output logic [3:0]  ack,
    output logic        eret_err
);

`ifdef EXC_HIVEC_EN
    localparam logic [31:0] VEC_BASE = 32'hFFFF_0000;
`else
    localparam logic [31:0] VEC_BASE = VECTOR_BASE;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SAVE   = 2'd1;
    localparam logic [1:0] S_SWITCH = 2'd2;
    localparam logic [1:0] S_RET    = 2'd3;

    localparam logic [2:0] M_CUR = 3'd0;
    localparam logic [2:0] M_FIQ = 3'd1;
    localparam logic [2:0] M_IRQ = 3'd2;
    localparam logic [2:0] M_SVC = 3'd3;
    localparam logic [2:0] M_UND = 3'd4;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [2:0]  target;
    logic [2:0]  target_nxt;
    logic        und_p;
    logic        svc_p;
    logic        unpriv_mode;

    logic        busy_d;
    logic [2:0]  change_m_d;
    logic        w_spsr_s_d;
    logic        write_spsr_d;
    logic [2:0]  w_cpsr_s_d;
    logic        write_cpsr_d;
    logic        write_reg_d;
    logic [3:0]  w_addr_d;
    logic [31:0] w_data_d;
    logic        write_pc_d;
    logic [31:0] pc_new_d;
    logic [3:0]  ack_d;
    logic        eret_err_d;

    assign unpriv_mode = (cpsr_in[4:0] == 5'b10000) || (cpsr_in[4:0] == 5'b11111);

    // Arbitrate in IDLE and walk the fixed SAVE->SWITCH or RET sequences.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        eret_err_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (eret_req) begin
                    if (unpriv_mode) begin
                        eret_err_d = 1'b1;
                    end else begin
                        state_nxt  = S_RET;
                        target_nxt = M_CUR;
                    end
                end else if (fiq_req && !cpsr_in[6]) begin
                    state_nxt  = S_SAVE;
                    target_nxt = M_FIQ;
                end else if (irq_req && !cpsr_in[7]) begin
                    state_nxt  = S_SAVE;
                    target_nxt = M_IRQ;
                end else if (und_p || und_req) begin
                    state_nxt  = S_SAVE;
                    target_nxt = M_UND;
                end else if (svc_p || svc_req) begin
                    state_nxt  = S_SAVE;
                    target_nxt = M_SVC;
                end
            end
            S_SAVE:   state_nxt = S_SWITCH;
            S_SWITCH: state_nxt = S_IDLE;
            S_RET:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Sequencer state and the latched exception target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            target <= M_CUR;
        end else begin
            state  <= state_nxt;
            target <= target_nxt;
        end
    end

    // Pulse requests are remembered until the SWITCH cycle that acks them; a new pulse wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            und_p <= 1'b0;
            svc_p <= 1'b0;
        end else begin
            und_p <= und_req | (und_p & ~((state == S_SWITCH) && (target == M_UND)));
            svc_p <= svc_req | (svc_p & ~((state == S_SWITCH) && (target == M_SVC)));
        end
    end

    // Decode the strobes for the state being entered so they can be registered.
    always_comb begin
        busy_d       = 1'b0;
        change_m_d   = M_CUR;
        w_spsr_s_d   = 1'b0;
        write_spsr_d = 1'b0;
        w_cpsr_s_d   = 3'd0;
        write_cpsr_d = 1'b0;
        write_reg_d  = 1'b0;
        w_addr_d     = 4'd0;
        w_data_d     = 32'd0;
        write_pc_d   = 1'b0;
        pc_new_d     = 32'd0;
        ack_d        = 4'b0000;
        case (state_nxt)
            S_SAVE: begin
                busy_d       = 1'b1;
                change_m_d   = target_nxt;
                write_spsr_d = 1'b1;
                w_spsr_s_d   = 1'b1;
                write_reg_d  = 1'b1;
                w_addr_d     = 4'd14;
                if ((target_nxt == M_FIQ) || (target_nxt == M_IRQ)) begin
                    w_data_d = pc_in + IRQ_LR_OFS;
                end else begin
                    w_data_d = pc_in;
                end
            end
            S_SWITCH: begin
                busy_d       = 1'b1;
                change_m_d   = target_nxt;
                write_cpsr_d = 1'b1;
                write_pc_d   = 1'b1;
                case (target_nxt)
                    M_FIQ: begin
                        w_cpsr_s_d = 3'd3;
                        pc_new_d   = VEC_BASE + 32'h1C;
                        ack_d      = 4'b1000;
                    end
                    M_IRQ: begin
                        w_cpsr_s_d = 3'd2;
                        pc_new_d   = VEC_BASE + 32'h18;
                        ack_d      = 4'b0100;
                    end
                    M_UND: begin
                        w_cpsr_s_d = 3'd5;
                        pc_new_d   = VEC_BASE + 32'h04;
                        ack_d      = 4'b0010;
                    end
                    M_SVC: begin
                        w_cpsr_s_d = 3'd4;
                        pc_new_d   = VEC_BASE + 32'h08;
                        ack_d      = 4'b0001;
                    end
                    default: begin
                        w_cpsr_s_d = 3'd0;
                        pc_new_d   = 32'd0;
                        ack_d      = 4'b0000;
                    end
                endcase
            end
            S_RET: begin
                busy_d       = 1'b1;
                change_m_d   = M_CUR;
                write_cpsr_d = 1'b1;
                w_cpsr_s_d   = 3'd0;
                write_pc_d   = 1'b1;
                pc_new_d     = lr_in;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered outputs keep the strobes stable ahead of the consumer's negedge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            Change_M   <= 3'd0;
            W_SPSR_s   <= 1'b0;
            Write_SPSR <= 1'b0;
            W_CPSR_s   <= 3'd0;
            Write_CPSR <= 1'b0;
            Write_Reg  <= 1'b0;
            W_Addr     <= 4'd0;
            W_Data     <= 32'd0;
            Write_PC   <= 1'b0;
            PC_New     <= 32'd0;
            ack        <= 4'b0000;
            eret_err   <= 1'b0;
        end else begin
            busy       <= busy_d;
            Change_M   <= change_m_d;
            W_SPSR_s   <= w_spsr_s_d;
            Write_SPSR <= write_spsr_d;
            W_CPSR_s   <= w_cpsr_s_d;
            Write_CPSR <= write_cpsr_d;
            Write_Reg  <= write_reg_d;
            W_Addr     <= w_addr_d;
            W_Data     <= w_data_d;
            Write_PC   <= write_pc_d;
            PC_New     <= pc_new_d;
            ack        <= ack_d;
            eret_err   <= eret_err_d;
        end
    end

endmodule

// File: tb/tb_exc_entry_ctrl.sv
// tb_exc_entry_ctrl: scoreboard bench for exc_entry_ctrl with directed
// scenarios followed by randomized transactions.
module tb_exc_entry_ctrl;

    typedef struct packed {
        logic        busy;
        logic [2:0]  change_m;
        logic        w_spsr_s;
        logic        write_spsr;
        logic [2:0]  w_cpsr_s;
        logic        write_cpsr;
        logic        write_reg;
        logic [3:0]  w_addr;
        logic [31:0] w_data;
        logic        write_pc;
        logic [31:0] pc_new;
        logic [3:0]  ack;
        logic        eret_err;
    } out_t;

    typedef enum int {EV_NONE, EV_ERR, EV_RET, EV_FIQ, EV_IRQ, EV_UND, EV_SVC} ev_t;

`ifdef EXC_HIVEC_EN
    localparam logic [31:0] BASE = 32'hFFFF_0000;
`else
    localparam logic [31:0] BASE = 32'h0000_0000;
`endif

    logic        clk;
    logic        rst;
    logic        fiq_req, irq_req, und_req, svc_req, eret_req;
    logic [31:0] cpsr_in, pc_in, lr_in;
    logic        busy;
    logic [2:0]  Change_M;
    logic        W_SPSR_s;
    logic        Write_SPSR;
    logic [2:0]  W_CPSR_s;
    logic        Write_CPSR;
    logic        Write_Reg;
    logic [3:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_PC;
    logic [31:0] PC_New;
    logic [3:0]  ack;
    logic        eret_err;

    out_t expq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   und_pend = 0;
    bit   svc_pend = 0;

    exc_entry_ctrl dut (
        .clk(clk), .rst(rst),
        .fiq_req(fiq_req), .irq_req(irq_req), .und_req(und_req),
        .svc_req(svc_req), .eret_req(eret_req),
        .cpsr_in(cpsr_in), .pc_in(pc_in), .lr_in(lr_in),
        .busy(busy), .Change_M(Change_M), .W_SPSR_s(W_SPSR_s),
        .Write_SPSR(Write_SPSR), .W_CPSR_s(W_CPSR_s), .Write_CPSR(Write_CPSR),
        .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data),
        .Write_PC(Write_PC), .PC_New(PC_New), .ack(ack), .eret_err(eret_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decision: which event an IDLE cycle with these inputs produces.
    function automatic ev_t pick(input bit fiq, input bit irq, input bit und,
                                 input bit svc, input bit eret, input logic [31:0] cpsr);
        if (eret) return ((cpsr[4:0] == 5'h10) || (cpsr[4:0] == 5'h1F)) ? EV_ERR : EV_RET;
        if (fiq && !cpsr[6]) return EV_FIQ;
        if (irq && !cpsr[7]) return EV_IRQ;
        if (und) return EV_UND;
        if (svc) return EV_SVC;
        return EV_NONE;
    endfunction

    // Queue the cycle-by-cycle outputs the event should produce.
    task automatic push_expect(input ev_t ev, input logic [31:0] pc, input logic [31:0] lr);
        out_t r;
        logic [2:0]  mode;
        logic [2:0]  src;
        logic [31:0] ofs;
        logic [3:0]  a;
        r = '0;
        case (ev)
            EV_ERR: begin
                r.eret_err = 1'b1;
                expq.push_back(r);
            end
            EV_RET: begin
                r.busy = 1; r.write_cpsr = 1; r.write_pc = 1; r.pc_new = lr;
                expq.push_back(r);
            end
            EV_FIQ, EV_IRQ, EV_UND, EV_SVC: begin
                case (ev)
                    EV_FIQ:  begin mode = 1; src = 3; ofs = 32'h1C; a = 4'b1000; end
                    EV_IRQ:  begin mode = 2; src = 2; ofs = 32'h18; a = 4'b0100; end
                    EV_UND:  begin mode = 4; src = 5; ofs = 32'h04; a = 4'b0010; end
                    default: begin mode = 3; src = 4; ofs = 32'h08; a = 4'b0001; end
                endcase
                r.busy = 1; r.change_m = mode; r.write_spsr = 1; r.w_spsr_s = 1;
                r.write_reg = 1; r.w_addr = 4'd14;
                r.w_data = (ev == EV_FIQ || ev == EV_IRQ) ? pc + 32'd4 : pc;
                expq.push_back(r);
                r = '0;
                r.busy = 1; r.change_m = mode; r.write_cpsr = 1; r.w_cpsr_s = src;
                r.write_pc = 1; r.pc_new = BASE + ofs; r.ack = a;
                expq.push_back(r);
            end
            default: ;
        endcase
    endtask

    // Monitor: pop an expectation whenever the DUT presents activity, otherwise require quiet outputs.
    initial begin
        out_t act;
        out_t exp_r;
        forever begin
            @(negedge clk);
            act = '{busy, Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR,
                    Write_Reg, W_Addr, W_Data, Write_PC, PC_New, ack, eret_err};
            n_checks++;
            if (busy || eret_err) begin
                if (expq.size() == 0) begin
                    n_errors++;
                    $display("[TB] FAIL unexpected_output t=%0t actual=%h required=none", $time, act);
                end else begin
                    exp_r = expq.pop_front();
                    if (act !== exp_r) begin
                        n_errors++;
                        $display("[TB] FAIL output_cycle t=%0t actual=%h required=%h", $time, act, exp_r);
                    end
                end
            end else if (act !== out_t'(0)) begin
                n_errors++;
                $display("[TB] FAIL idle_outputs t=%0t actual=%h required=0", $time, act);
            end
        end
    end

    // Drive one IDLE-cycle transaction and follow it through its sequence.
    task automatic apply_stimulus(input bit fiq, input bit irq, input bit und, input bit svc,
                                  input bit eret, input logic [31:0] cpsr, input logic [31:0] pc,
                                  input logic [31:0] lr, input bit mid_und, input bit mid_svc);
        ev_t ev;
        @(negedge clk);
        fiq_req = fiq; irq_req = irq; und_req = und; svc_req = svc; eret_req = eret;
        cpsr_in = cpsr; pc_in = pc; lr_in = lr;
        ev = pick(fiq, irq, und | und_pend, svc | svc_pend, eret, cpsr);
        push_expect(ev, pc, lr);
        und_pend |= und;
        svc_pend |= svc;
        if (ev == EV_FIQ || ev == EV_IRQ || ev == EV_UND || ev == EV_SVC) begin
            @(negedge clk);
            fiq_req = 0; irq_req = 0; eret_req = 0;
            und_req = mid_und; svc_req = mid_svc;
            und_pend |= mid_und;
            svc_pend |= mid_svc;
            @(negedge clk);
            und_req = 0; svc_req = 0;
            if (ev == EV_UND) und_pend = 0;
            if (ev == EV_SVC) svc_pend = 0;
        end else if (ev == EV_RET) begin
            @(negedge clk);
            fiq_req = 0; irq_req = 0; und_req = 0; svc_req = 0; eret_req = 0;
        end
    endtask

    // Abort an IRQ entry with reset while the SAVE strobes are on the outputs.
    task automatic reset_mid_save(input logic [31:0] pc);
        @(negedge clk);
        fiq_req = 0; irq_req = 1; und_req = 0; svc_req = 0; eret_req = 0;
        cpsr_in = 32'h10; pc_in = pc;
        push_expect(EV_IRQ, pc, lr_in);
        void'(expq.pop_back());
        @(negedge clk);
        irq_req = 0;
        #2 rst = 1;
        und_pend = 0;
        svc_pend = 0;
        @(negedge clk);
        #2 rst = 0;
    endtask

    // Main stimulus: reset, directed scenarios, then random traffic.
    initial begin
        logic [4:0] modes [7];
        logic [31:0] cpsr;
        modes = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};
        rst = 1;
        fiq_req = 0; irq_req = 0; und_req = 0; svc_req = 0; eret_req = 0;
        cpsr_in = 32'h10; pc_in = 0; lr_in = 0;
        repeat (3) @(negedge clk);
        rst = 0;

        apply_stimulus(0, 1, 0, 0, 0, 32'h10, 32'h100, 32'h0, 0, 0);
        apply_stimulus(1, 1, 0, 1, 0, 32'h10, 32'h200, 32'h0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0, 32'h10, 32'h240, 32'h0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0, 32'h92, 32'h300, 32'h0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0, 32'h10, 32'h400, 32'h0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 32'h90, 32'h440, 32'h0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 32'h92, 32'h500, 32'h200, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 32'h10, 32'h500, 32'h200, 0, 0);
        reset_mid_save(32'h600);
        apply_stimulus(0, 0, 1, 0, 0, 32'h10, 32'h700, 32'h0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            cpsr = {24'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                    modes[$urandom_range(0, 6)]};
            apply_stimulus($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 30,
                           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
                           $urandom_range(0, 99) < 12, cpsr,
                           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20);
        end

        @(negedge clk);
        fiq_req = 0; irq_req = 0; und_req = 0; svc_req = 0; eret_req = 0;
        cpsr_in = 32'hD3;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (expq.size() != 0) begin
            n_errors++;
            $display("[TB] FAIL pending_expectations actual=%0d required=0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
